// File: rtl/mod3_fwd_conv_serial.sv
// Bit-serial binary -> residue mod 3 converter, LSB first, one bit per clock.
// Optional macro MOD3_EARLY_EXIT_EN: finish as soon as the remaining operand bits are all zero.
module mod3_fwd_conv_serial #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_res,
    output logic              busy,
    output logic [1:0]        dbg_state
);
    localparam int IDX_W = $clog2(DATA_W) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] sh;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        acc;

    logic [2:0]        wgt;
    logic [2:0]        t;
    logic [2:0]        t_red;
    logic [1:0]        acc_nxt;
    logic [DATA_W-1:0] sh_nxt;
    logic              last;

    // Bit i weighs 2^i mod 3: 1 for even i, 2 for odd i. t never exceeds 4.
    always_comb begin
        wgt     = sh[0] ? (idx[0] ? 3'd2 : 3'd1) : 3'd0;
        t       = {1'b0, acc} + wgt;
        t_red   = (t >= 3'd3) ? (t - 3'd3) : t;
        acc_nxt = t_red[1:0];
        sh_nxt  = sh >> 1;
`ifdef MOD3_EARLY_EXIT_EN
        last    = (idx == LAST_IDX) || (sh_nxt == '0);
`else
        last    = (idx == LAST_IDX);
`endif
    end

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never waits on ready, and in_ready/out_valid are never high in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sh        <= '0;
            idx       <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh       <= in_data;
                        idx      <= '0;
                        acc      <= '0;
                        state    <= ACCUM;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ACCUM: begin
                    acc <= acc_nxt;
                    sh  <= sh_nxt;
                    idx <= idx + 1'b1;
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_res   = acc;
    assign dbg_state = state;
endmodule
